// File: rtl/seg7_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | seg7_pkg : shared hex font and types for the 7-segment display path   |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
package seg7_pkg;

   typedef logic [1:0] digit_idx_t;

   // Active-high segment pattern meaning "nothing lit".
   localparam logic [6:0] c_SEG_OFF = 7'h00;

   // Active-high font, bit order {g,f,e,d,c,b,a}.
   localparam logic [6:0] c_HEX_FONT [16] = '{
      7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
      7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
   };

endpackage
`default_nettype wire

// File: rtl/hex7_decode.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | hex7_decode : combinational nibble to 7-segment lookup               |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
module hex7_decode
   import seg7_pkg::*;
#(
   parameter int ACTIVE_LOW = 1
)(
   input  logic [3:0] i_nibble,
   output logic [6:0] o_seg
);

   assign o_seg = (ACTIVE_LOW != 0) ? ~c_HEX_FONT[i_nibble] : c_HEX_FONT[i_nibble];

endmodule
`default_nettype wire

// File: rtl/seg7_scan_driver.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | seg7_scan_driver : double-buffered 4-digit multiplexed hex display    |
// | Optional: SEG7_LEADING_ZERO_BLANK_EN blanks leading zero digits.      |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
module seg7_scan_driver
   import seg7_pkg::*;
#(
   parameter int SCAN_DIV       = 1024,
   parameter int BLANK_CYC      = 16,
   parameter int SEG_ACTIVE_LOW = 1,
   parameter int AN_ACTIVE_LOW  = 1
)(
   input  logic        clk,
   input  logic        rst_n,
   input  logic [15:0] data_in,
   input  logic [3:0]  dp_in,
   input  logic        data_valid,
   output logic        data_ready,
   output logic [6:0]  seg_out,
   output logic        dp_out,
   output logic [3:0]  an_out,
   output logic        frame_start
);

   localparam int              c_PW        = $clog2(SCAN_DIV);
   localparam logic [c_PW-1:0] c_PRESC_MAX = c_PW'(SCAN_DIV - 1);
   localparam logic [c_PW-1:0] c_BLANK     = c_PW'(BLANK_CYC);
   localparam logic [3:0]      c_AN_OFF    = (AN_ACTIVE_LOW != 0) ? 4'hF : 4'h0;
   localparam logic [6:0]      c_SEG_IDLE  = (SEG_ACTIVE_LOW != 0) ? ~c_SEG_OFF : c_SEG_OFF;
   localparam logic            c_DP_IDLE   = (SEG_ACTIVE_LOW != 0);

   logic [c_PW-1:0] r_presc;
   digit_idx_t      r_idx;
   logic [15:0]     r_disp;
   logic [3:0]      r_dp;
   logic [15:0]     r_shadow;
   logic [3:0]      r_shadow_dp;
   logic            r_pending;

   logic [c_PW-1:0] w_presc_nxt;
   digit_idx_t      w_idx_nxt;
   logic            w_wrap;
   logic            w_frame_end;
   logic            w_xfer;
   logic            w_load;
   logic            w_pending_nxt;
   logic [15:0]     w_disp_nxt;
   logic [3:0]      w_dp_nxt;
   logic [3:0]      w_nibble;
   logic            w_dp_bit;
   logic            w_lead_blank;
   logic [6:0]      w_seg_dec;
   logic [3:0]      w_an_onehot;
   logic [3:0]      w_an_nxt;

   assign w_wrap        = (r_presc == c_PRESC_MAX);
   assign w_frame_end   = w_wrap && (r_idx == 2'd3);
   assign w_xfer        = data_valid && data_ready;
   assign w_load        = w_frame_end && r_pending;
   assign w_pending_nxt = w_xfer || (r_pending && !w_load);
   assign w_presc_nxt   = w_wrap ? '0 : r_presc + 1'b1;
   assign w_idx_nxt     = w_wrap ? r_idx + 2'd1 : r_idx;

   // Decode from the next-state display so the first digit of a new frame
   // already shows the freshly loaded word.
   assign w_disp_nxt = w_load ? r_shadow    : r_disp;
   assign w_dp_nxt   = w_load ? r_shadow_dp : r_dp;
   assign w_nibble   = w_disp_nxt[{w_idx_nxt, 2'b00} +: 4];
   assign w_dp_bit   = w_dp_nxt[w_idx_nxt];

`ifdef SEG7_LEADING_ZERO_BLANK_EN
   digit_idx_t w_msd;
   always_comb begin
      w_msd = '0;
      for (int i = 1; i < 4; i++) begin
         if (w_disp_nxt[4*i +: 4] != 4'h0) w_msd = digit_idx_t'(i);
      end
   end
   assign w_lead_blank = (w_idx_nxt > w_msd) && !w_dp_bit;
`else
   assign w_lead_blank = 1'b0;
`endif

   hex7_decode #(
      .ACTIVE_LOW (SEG_ACTIVE_LOW)
   ) u_hex7_decode (
      .i_nibble (w_nibble),
      .o_seg    (w_seg_dec)
   );

   assign w_an_onehot = 4'b0001 << w_idx_nxt;
   assign w_an_nxt    = (w_presc_nxt < c_BLANK) ? c_AN_OFF
                      : ((AN_ACTIVE_LOW != 0) ? ~w_an_onehot : w_an_onehot);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_presc     <= '0;
         r_idx       <= '0;
         r_disp      <= '0;
         r_dp        <= '0;
         r_shadow    <= '0;
         r_shadow_dp <= '0;
         r_pending   <= 1'b0;
         data_ready  <= 1'b1;
         frame_start <= 1'b0;
         an_out      <= c_AN_OFF;
         seg_out     <= c_SEG_IDLE;
         dp_out      <= c_DP_IDLE;
      end else begin
         r_presc     <= w_presc_nxt;
         r_idx       <= w_idx_nxt;
         r_disp      <= w_disp_nxt;
         r_dp        <= w_dp_nxt;
         r_pending   <= w_pending_nxt;
         data_ready  <= !w_pending_nxt;
         frame_start <= w_frame_end;
         an_out      <= w_an_nxt;
         seg_out     <= w_lead_blank ? c_SEG_IDLE : w_seg_dec;
         dp_out      <= (SEG_ACTIVE_LOW != 0) ? !w_dp_bit : w_dp_bit;
         if (w_xfer) begin
            r_shadow    <= data_in;
            r_shadow_dp <= dp_in;
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_seg7_scan_driver.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_seg7_scan_driver : randomized self-checking bench, 8-cycle slots   |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
module tb_seg7_scan_driver;

   localparam int c_DIV   = 8;
   localparam int c_BLANK = 2;
   localparam int c_FRAME = 4 * c_DIV;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [15:0] data_in = '0;
   logic [3:0]  dp_in = '0;
   logic        data_valid = 1'b0;
   logic        data_ready;
   logic [6:0]  seg_out;
   logic        dp_out;
   logic [3:0]  an_out;
   logic        frame_start;

   int checks = 0;
   int errors = 0;

   // Active-high hex glyphs {g,f,e,d,c,b,a}.
   logic [6:0] font [16] = '{
      7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
      7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
   };

   // Reference model: cycle count since reset release, visible word, FIFO of accepted words.
   int           m_t = 0;
   logic [15:0]  m_disp = '0;
   logic [3:0]   m_dpv = '0;
   logic [19:0]  m_q [$];
   int           m_accepts = 0;
   bit           m_rdy;

   seg7_scan_driver #(
      .SCAN_DIV       (c_DIV),
      .BLANK_CYC      (c_BLANK),
      .SEG_ACTIVE_LOW (1),
      .AN_ACTIVE_LOW  (1)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .data_in     (data_in),
      .dp_in       (dp_in),
      .data_valid  (data_valid),
      .data_ready  (data_ready),
      .seg_out     (seg_out),
      .dp_out      (dp_out),
      .an_out      (an_out),
      .frame_start (frame_start)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h (t=%0d)", name, act, exp, m_t);
      end
   endtask

   task automatic timeout(input string name);
      checks++;
      errors++;
      $display("FAIL %s: timed out waiting", name);
   endtask

   initial begin
      forever begin
         @(posedge clk or negedge rst_n);
         if (!rst_n) begin
            m_t = 0;
            m_disp = '0;
            m_dpv = '0;
            m_q.delete();
         end else begin
            m_rdy = (m_q.size() == 0);
            if ((m_t % c_FRAME) == c_FRAME - 1 && m_q.size() > 0)
               {m_dpv, m_disp} = m_q.pop_front();
            if (data_valid && m_rdy) begin
               m_q.push_back({dp_in, data_in});
               m_accepts++;
            end
            m_t++;
         end
      end
   end

   // Per-cycle compare against the model.
   initial begin
      int p, idx, msd;
      logic [3:0] nib;
      logic       blank;
      logic [6:0] e_seg;
      logic [3:0] e_an;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            check("idle_an", an_out, 4'hF);
            check("idle_seg", seg_out, 7'h7F);
            check("idle_dp", dp_out, 1'b1);
            check("idle_fs", frame_start, 1'b0);
            check("idle_rdy", data_ready, 1'b1);
         end else begin
            p   = m_t % c_DIV;
            idx = (m_t / c_DIV) % 4;
            nib = m_disp[4*idx +: 4];
            blank = 1'b0;
`ifdef SEG7_LEADING_ZERO_BLANK_EN
            msd = 0;
            for (int k = 0; k < 4; k++) if (m_disp[4*k +: 4] != 0) msd = k;
            blank = (idx > msd) && !m_dpv[idx];
`else
            msd = 3;
`endif
            e_seg = blank ? 7'h7F : ~font[nib];
            e_an  = (p < c_BLANK) ? 4'hF : ~(4'b0001 << idx);
            check("an", an_out, e_an);
            check("seg", seg_out, e_seg);
            check("dp", dp_out, !m_dpv[idx]);
            check("frame_start", frame_start, (m_t > 0) && (m_t % c_FRAME == 0));
            check("ready", data_ready, m_q.size() == 0);
         end
      end
   end

   // Called at a negedge; returns at the negedge after acceptance with valid dropped.
   task automatic send(input logic [15:0] v, input logic [3:0] d);
      int start;
      bit ok;
      start = m_accepts;
      ok = 1'b0;
      data_in = v;
      dp_in = d;
      data_valid = 1'b1;
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         if (m_accepts != start) begin
            ok = 1'b1;
            break;
         end
      end
      data_valid = 1'b0;
      if (!ok) timeout("send");
   endtask

   task automatic wait_disp(input logic [15:0] v);
      bit ok;
      ok = 1'b0;
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         if (m_disp == v && m_t % c_FRAME != 0) begin
            ok = 1'b1;
            break;
         end
      end
      if (!ok) timeout("wait_disp");
   endtask

   task automatic wait_slot(input int target);
      bit ok;
      ok = 1'b0;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (rst_n && (m_t % c_FRAME) == target) begin
            ok = 1'b1;
            break;
         end
      end
      if (!ok) timeout("wait_slot");
   endtask

   initial begin
      logic [15:0] rv;
      logic [3:0]  rd;
      repeat (3) @(negedge clk);
      check("rst_an_lit", an_out, 4'hF);
      check("rst_seg_lit", seg_out, 7'h7F);
      #1 rst_n = 1'b1;
      @(negedge clk);
      check("ready_after_release", data_ready, 1'b1);
      check("an_t1_blank", an_out, 4'hF);
      @(negedge clk);
      check("an_t2_digit0", an_out, 4'hE);

      send(16'h1234, 4'h0);
      check("ready_low_after_xfer", data_ready, 1'b0);
      wait_disp(16'h1234);
      wait_slot(4);
      check("d0_shows_4", seg_out, 7'h19);
      check("d0_anode", an_out, 4'hE);
      wait_slot(3 * c_DIV + 4);
      check("d3_shows_1", seg_out, 7'h79);
      check("d3_anode", an_out, 4'h7);
      check("ready_high_after_load", data_ready, 1'b1);

      // Back-to-back: second word stalls until the boundary frees the shadow.
      @(negedge clk);
      send(16'hABCD, 4'h0);
      check("stall_ready_low", data_ready, 1'b0);
      send(16'h5678, 4'b1010);
      check("model_disp_abcd", m_disp, 16'hABCD);
      wait_disp(16'h5678);
      wait_slot(3 * c_DIV + 4);
      check("d3_shows_5", seg_out, 7'h12);
      check("d3_dp_on", dp_out, 1'b0);

      // Random words and gaps, landing handshakes at all frame phases.
      for (int n = 0; n < 30; n++) begin
         repeat ($urandom_range(0, 70)) @(negedge clk);
         rv = 16'($urandom);
         rd = 4'($urandom);
         send(rv, rd);
      end
      repeat (2 * c_FRAME) @(negedge clk);

      // Asynchronous reset in the middle of the digit 2 slot.
      wait_slot(2 * c_DIV + 4);
      @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      check("async_an", an_out, 4'hF);
      check("async_seg", seg_out, 7'h7F);
      check("async_dp", dp_out, 1'b1);
      repeat (2) @(negedge clk);
      #1 rst_n = 1'b1;
      wait_slot(4);
      check("post_rst_d0", seg_out, 7'h40);
      wait_slot(3 * c_DIV + 4);
`ifdef SEG7_LEADING_ZERO_BLANK_EN
      check("post_rst_d3", seg_out, 7'h7F);
`else
      check("post_rst_d3", seg_out, 7'h40);
`endif

`ifdef SEG7_LEADING_ZERO_BLANK_EN
      @(negedge clk);
      send(16'h0040, 4'b0100);
      wait_disp(16'h0040);
      wait_slot(4);
      check("lz_d0", seg_out, 7'h40);
      wait_slot(c_DIV + 4);
      check("lz_d1", seg_out, 7'h19);
      wait_slot(2 * c_DIV + 4);
      check("lz_d2", seg_out, 7'h40);
      check("lz_d2_dp", dp_out, 1'b0);
      wait_slot(3 * c_DIV + 4);
      check("lz_d3", seg_out, 7'h7F);
`endif

      repeat (4) @(negedge clk);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
